rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Access controller for the 16-entry, 8-bit register file. Owns the register file's write port and one read address. After reset it zeroes every register with a sequential sweep. It then lets the core use the register file freely. A debug/loader requester gets slots when the core is idle, or when a starvation limit forces a one-cycle core stall.

## Interface

Parameters:
- W, 8, data width
- D, 4, register address width (2**D registers)
- STARVE_LIMIT, 4, consecutive denied cycles before debug preempts the core

Ports:
- CLK  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- core_valid  in  1  core uses the register file this cycle
- core_we  in  1  core write enable (meaningful only with core_valid)
- core_addr  in  D  core write address
- core_data  in  W  core write data
- core_stall  out  1  core must hold its request; port taken by controller
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_wr  in  1  1 = write, 0 = read; stable while dbg_req
- dbg_addr  in  D  debug register address
- dbg_wdata  in  W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  W  read data, valid with dbg_ack, held until next read ack
- clr_req  in  1  soft request to re-zero all registers
- rf_we  out  1  register file write enable
- rf_waddr  out  D  register file write address
- rf_wdata  out  W  register file write data
- rf_raddr  out  D  register file read address (debug read)
- rf_rdata  in  W  register file combinational read data at rf_raddr
- init_done  out  1  high once a sweep completes; low during any sweep

## Operation

- States: SWEEP, IDLE, DBG_GRANT, DBG_ACK.
- **SWEEP**
  - rf_we=1, rf_waddr=sweep_cnt, rf_wdata=0.
  - sweep_cnt increments each cycle and wraps after 2**D-1.
  - core_stall=1 and init_done=0 for the whole sweep.
  - After writing address 2**D-1, go to IDLE and set init_done=1.
- **IDLE**
  - Core path: rf_we/rf_waddr/rf_wdata = core_valid&core_we / core_addr / core_data; core_stall=0.
  - clr_req: reset sweep_cnt to 0 and go to SWEEP next cycle. clr_req has priority over dbg_req; a pending dbg_req stays pending through the sweep.
  - dbg_req with core_valid=0: go to DBG_GRANT.
  - dbg_req with core_valid=1: increment starve_cnt. When starve_cnt reaches STARVE_LIMIT, go to DBG_GRANT anyway.
- **DBG_GRANT** (one cycle)
  - core_stall=1; core request ignored.
  - Write: rf_we=1, rf_waddr=dbg_addr, rf_wdata=dbg_wdata.
  - Read: rf_we=0, rf_raddr=dbg_addr; register rf_rdata into dbg_rdata.
  - Clear starve_cnt; go to DBG_ACK.
- **DBG_ACK** (one cycle)
  - dbg_ack=1; core path active as in IDLE; go to IDLE.
  - The requester drops dbg_req in this cycle; a request still high on return to IDLE counts as a new request.
- starve_cnt: width $clog2(STARVE_LIMIT+1), saturating. Clears on grant and whenever dbg_req=0.
- rf_raddr = dbg_addr at all times outside SWEEP; 0 during SWEEP.

## Timing

- Reset values (async, while reset_n=0):
  - state=SWEEP, sweep_cnt=0, starve_cnt=0.
  - dbg_ack=0, dbg_rdata=0, init_done=0, core_stall=1.
  - rf_we=0 while reset_n is low.
- The first sweep write is in the first clock edge after reset release.
- A sweep takes 2**D cycles (16 by default). init_done rises on the edge after the last write.
- Debug latency with the core idle: dbg_req seen in IDLE → DBG_GRANT next cycle → dbg_ack the cycle after. The ack arrives 2 cycles after the first sampled request.
- Worst case with the core always busy: STARVE_LIMIT+2 cycles to ack.
- At most one debug access per 3 cycles.
- Reset asserted mid-sweep or mid-debug aborts the operation immediately. No ack is produced; the sweep restarts from address 0.
- Outputs rf_we, rf_waddr, rf_wdata, core_stall and rf_raddr are combinational from state and inputs. dbg_ack, dbg_rdata and init_done are registered.

## Structure

- Shared definitions package: state enum type (SWEEP, IDLE, DBG_GRANT, DBG_ACK) and a default STARVE_LIMIT constant.
- No sub-modules required.
- Integration: this block's rf_* ports drive the register file's write path. The register file's internal reset clear becomes redundant and is driven inactive.

## Test plan

- Reset release: 16 cycles of rf_we=1, rf_waddr 0..15, rf_wdata=0, core_stall=1 → init_done=1 at cycle 17, core_stall=0.
- Core idle, debug write addr 5 data 0xA7 → rf_we with addr 5 / 0xA7 one cycle after request; dbg_ack the next cycle. Then debug read addr 5 → dbg_rdata=0xA7 with dbg_ack.
- core_valid held high and dbg_req raised → denied 4 cycles, then one core_stall cycle with the debug write. dbg_ack arrives 6 cycles after the request.
- clr_req and dbg_req asserted together in IDLE → full 16-cycle sweep first, then the debug access granted and acked.
- reset_n pulsed low during DBG_GRANT → no dbg_ack; new sweep from address 0; dbg_rdata=0.
- Core write addr 3 data 0x55 in IDLE → rf_we/addr 3/0x55 in the same cycle, core_stall=0.

Source files
------------

// File: rtl/rf_access_ctrl_pkg.sv
// Shared types and defaults for the register-file access controller.
package rf_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SWEEP     = 2'd0,
        IDLE      = 2'd1,
        DBG_GRANT = 2'd2,
        DBG_ACK   = 2'd3
    } state_e;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/rf_access_ctrl.sv
// Arbitrates the register-file write port between a zeroing sweep, the core and a debug requester.
// Core path is zero-latency; debug acks 2 cycles after grant decision; debug preempts after STARVE_LIMIT busy cycles.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int W            = 8,
    parameter int D            = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         core_valid,
    input  logic         core_we,
    input  logic [D-1:0] core_addr,
    input  logic [W-1:0] core_data,
    output logic         core_stall,
    input  logic         dbg_req,
    input  logic         dbg_wr,
    input  logic [D-1:0] dbg_addr,
    input  logic [W-1:0] dbg_wdata,
    output logic         dbg_ack,
    output logic [W-1:0] dbg_rdata,
    input  logic         clr_req,
    output logic         rf_we,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_wdata,
    output logic [D-1:0] rf_raddr,
    input  logic [W-1:0] rf_rdata,
    output logic         init_done
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [D-1:0]    LAST_ADDR  = '1;

    state_e          state_q, state_d;
    logic [D-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [W-1:0]    dbg_rdata_q, dbg_rdata_d;
    logic            init_done_q, init_done_d;

    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        starve_cnt_d = starve_cnt_q;
        dbg_ack_d    = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        init_done_d  = init_done_q;
        case (state_q)
            SWEEP: begin
                sweep_cnt_d = sweep_cnt_q + D'(1);
                if (sweep_cnt_q == LAST_ADDR) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    sweep_cnt_d = '0;
                    state_d     = SWEEP;
                    init_done_d = 1'b0;
                end else if (dbg_req) begin
                    // Grant on an idle core, or once the starvation budget is spent.
                    if (!core_valid || starve_cnt_q == STARVE_MAX) begin
                        state_d = DBG_GRANT;
                    end else begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end
            end
            DBG_GRANT: begin
                starve_cnt_d = '0;
                state_d      = DBG_ACK;
                dbg_ack_d    = 1'b1;
                if (!dbg_wr) begin
                    dbg_rdata_d = rf_rdata;
                end
            end
            DBG_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = SWEEP;
            end
        endcase
        if (!dbg_req) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SWEEP;
            sweep_cnt_q  <= '0;
            starve_cnt_q <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_rdata_q  <= dbg_rdata_d;
            init_done_q  <= init_done_d;
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = core_addr;
        rf_wdata   = core_data;
        rf_raddr   = dbg_addr;
        core_stall = 1'b1;
        case (state_q)
            SWEEP: begin
                rf_we    = 1'b1;
                rf_waddr = sweep_cnt_q;
                rf_wdata = '0;
                rf_raddr = '0;
            end
            IDLE, DBG_ACK: begin
                rf_we      = core_valid & core_we;
                core_stall = 1'b0;
            end
            DBG_GRANT: begin
                rf_we    = dbg_wr;
                rf_waddr = dbg_addr;
                rf_wdata = dbg_wdata;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
        // State sits in SWEEP during reset; keep the register file untouched until release.
        rf_we = rf_we & reset_n;
    end

    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl with an attached behavioural register file.
module tb_rf_access_ctrl;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int LIM = 4;
    localparam int N   = 16;

    logic         CLK = 1'b0;
    logic         reset_n = 1'b0;
    logic         core_valid = 1'b0, core_we = 1'b0;
    logic [D-1:0] core_addr = '0;
    logic [W-1:0] core_data = '0;
    logic         core_stall;
    logic         dbg_req = 1'b0, dbg_wr = 1'b0;
    logic [D-1:0] dbg_addr = '0;
    logic [W-1:0] dbg_wdata = '0;
    logic         dbg_ack;
    logic [W-1:0] dbg_rdata;
    logic         clr_req = 1'b0;
    logic         rf_we;
    logic [D-1:0] rf_waddr, rf_raddr;
    logic [W-1:0] rf_wdata, rf_rdata;
    logic         init_done;

    always #5 CLK = ~CLK;

    rf_access_ctrl #(.W(W), .D(D), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .core_valid(core_valid), .core_we(core_we), .core_addr(core_addr),
        .core_data(core_data), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .clr_req(clr_req), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .init_done(init_done)
    );

    logic [W-1:0] rf_mem [N];
    always @(posedge CLK) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_raddr];

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc; int rdata; } ack_t;

    wr_t  wq[$];
    ack_t aq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_stall = 1'b1;
    logic exp_init = 1'b0;
    int   mdl [N];
    int   last_rd = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops expected register-file writes and debug acks as the DUT presents them.
    always @(negedge CLK) begin
        wr_t  w;
        ack_t a;
        if (rf_we) begin
            if (wq.size() == 0) chk("rf_unexpected_write", int'(rf_we), 0);
            else begin
                w = wq.pop_front();
                chk("rf_waddr", int'(rf_waddr), w.addr);
                chk("rf_wdata", int'(rf_wdata), w.data);
            end
        end else if (wq.size() != 0) begin
            chk("rf_missing_write", int'(rf_we), 1);
            void'(wq.pop_front());
        end
        if (reset_n) begin
            chk("core_stall", int'(core_stall), int'(exp_stall));
            chk("init_done", int'(init_done), int'(exp_init));
        end
        if (dbg_ack) begin
            if (aq.size() == 0) chk("dbg_ack_unexpected", int'(dbg_ack), 0);
            else begin
                a = aq.pop_front();
                chk("dbg_ack_cycle", cyc, a.cyc);
                chk("dbg_rdata", int'(dbg_rdata), a.rdata);
            end
        end else if (aq.size() != 0 && cyc >= aq[0].cyc) begin
            chk("dbg_ack_missing", int'(dbg_ack), 1);
            void'(aq.pop_front());
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic core_rand(input int busy_pct, input bit accepted);
        core_valid = ($urandom_range(99) < busy_pct);
        core_we    = 1'($urandom_range(1));
        core_addr  = 4'($urandom_range(N - 1));
        core_data  = 8'($urandom_range(255));
        if (accepted && core_valid && core_we) begin
            wq.push_back('{int'(core_addr), int'(core_data)});
            mdl[core_addr] = int'(core_data);
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < N; i++) begin
            exp_stall = 1'b1;
            exp_init  = 1'b0;
            core_rand(50, 1'b0);
            wq.push_back('{i, 0});
            mdl[i] = 0;
            step();
        end
        exp_stall = 1'b0;
        exp_init  = 1'b1;
    endtask

    // Grant happens on the first request cycle with the core idle, or after LIM busy cycles.
    task automatic dbg_txn(input bit wr, input int addr, input int wdata, input int busy_pct);
        dbg_req   = 1'b1;
        dbg_wr    = wr;
        dbg_addr  = 4'(addr);
        dbg_wdata = 8'(wdata);
        clr_req   = 1'b0;
        for (int k = 0; k <= LIM; k++) begin
            exp_stall = 1'b0;
            core_rand(busy_pct, 1'b1);
            if (!core_valid || k == LIM) break;
            step();
        end
        step();
        exp_stall = 1'b1;
        core_rand(100, 1'b0);
        if (wr) begin
            wq.push_back('{addr, wdata});
            mdl[addr] = wdata;
        end else begin
            last_rd = mdl[addr];
        end
        aq.push_back('{cyc + 1, last_rd});
        step();
        dbg_req   = 1'b0;
        exp_stall = 1'b0;
        core_rand(busy_pct, 1'b1);
        step();
    endtask

    initial begin
        int pct [4];
        pct[0] = 0; pct[1] = 30; pct[2] = 70; pct[3] = 100;

        repeat (3) @(negedge CLK);
        chk("rst_rf_we", int'(rf_we), 0);
        chk("rst_core_stall", int'(core_stall), 1);
        chk("rst_dbg_ack", int'(dbg_ack), 0);
        chk("rst_dbg_rdata", int'(dbg_rdata), 0);
        chk("rst_init_done", int'(init_done), 0);
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        sweep();

        core_valid = 1'b1; core_we = 1'b1; core_addr = 4'd3; core_data = 8'h55;
        wq.push_back('{3, 'h55});
        mdl[3] = 'h55;
        step();

        dbg_txn(1'b1, 5, 'hA7, 0);
        dbg_txn(1'b0, 5, 0, 0);
        dbg_txn(1'b1, 9, 'h3C, 100);
        dbg_txn(1'b0, 9, 0, 100);

        // clr_req wins over a simultaneous debug request, which waits out the sweep.
        clr_req = 1'b1; dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 4'd12; dbg_wdata = 8'h5A;
        core_valid = 1'b0; core_we = 1'b0; exp_stall = 1'b0;
        step();
        clr_req = 1'b0;
        sweep();
        dbg_txn(1'b1, 12, 'h5A, 100);
        dbg_txn(1'b0, 5, 0, 0);
        dbg_txn(1'b1, 5, 'h99, 0);
        dbg_txn(1'b0, 5, 0, 0);

        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 4'd12;
        core_valid = 1'b0; exp_stall = 1'b0;
        step();
        reset_n = 1'b0;
        dbg_req = 1'b0;
        wq.delete();
        aq.delete();
        last_rd = 0;
        @(negedge CLK);
        chk("abort_dbg_ack", int'(dbg_ack), 0);
        chk("abort_dbg_rdata", int'(dbg_rdata), 0);
        chk("abort_init_done", int'(init_done), 0);
        chk("abort_rf_we", int'(rf_we), 0);
        step();
        step();
        reset_n = 1'b1;
        sweep();
        for (int i = 0; i < 4; i++) begin
            exp_stall = 1'b0;
            core_rand(50, 1'b1);
            step();
        end

        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(9));
            if (r == 0) begin
                clr_req = 1'b1; dbg_req = 1'b0; exp_stall = 1'b0;
                core_rand(50, 1'b1);
                step();
                clr_req = 1'b0;
                sweep();
            end else if (r <= 5) begin
                dbg_txn(1'($urandom_range(1)), int'($urandom_range(N - 1)),
                        int'($urandom_range(255)), pct[$urandom_range(3)]);
            end else begin
                exp_stall = 1'b0;
                core_rand(60, 1'b1);
                step();
            end
        end

        core_valid = 1'b0; dbg_req = 1'b0; exp_stall = 1'b0;
        repeat (4) step();
        chk("wq_drained", wq.size(), 0);
        chk("aq_drained", aq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
